spi_master_ctrl: RTL

SPI initiator (mode 0: CPOL=0, CPHA=0) for the user project, clocked from the Wishbone clock. It drives the far end of the SPI link that our SPI slave block serves on the `io` pads. Internal logic hands it one word at a time over a valid/ready handshake. It shifts the word out MSB-first on MOSI while capturing MISO, then returns the received word with a one-cycle valid pulse.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_clk_div.sv | 38 +++
 rtl/spi_master_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master controller and the SPI slave side.
//   spi_state_e   : transfer FSM states
//   SCK_IDLE/...  : mode-0 line polarities (SCK idles low, CSB active-low)
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    localparam logic SCK_IDLE     = 1'b0;
    localparam logic SCK_ACTIVE   = ~SCK_IDLE;
    localparam logic CSB_INACTIVE = 1'b1;
    localparam logic CSB_ACTIVE   = ~CSB_INACTIVE;

endpackage

// File: rtl/spi_clk_div.sv
// Phase timer for the SPI master: counts 0..CLK_DIV-1 and ticks phase_end
// on the last count of every phase.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : restart the count (asserted on state entry / while idle)
//   phase_end  : high during the final cycle of a CLK_DIV-cycle phase
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic phase_end
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("spi_clk_div: CLK_DIV must be >= 2");
        end
    endgenerate

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign phase_end = (cnt == LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master. Accepts one word on a valid/ready handshake, shifts it
// out MSB-first on MOSI while capturing MISO, then returns the received word
// with a one-cycle rx_valid_o pulse.
//   wb_clk_i, wb_rst_i            : clock, asynchronous active-high reset
//   tx_valid_i/tx_ready_o/tx_data_i : word input handshake
//   rx_valid_o/rx_data_o          : received word (pulse / held data)
//   busy_o                        : transfer in progress (not IDLE)
//   spi_sck_o/spi_csb_o/spi_mosi_o/spi_miso_i : SPI pins
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic             rx_valid_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             busy_o,
    output logic             spi_sck_o,
    output logic             spi_csb_o,
    output logic             spi_mosi_o,
    input  logic             spi_miso_i
);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("spi_master_ctrl: WIDTH must be >= 2");
        end
    endgenerate

    localparam int unsigned HCW = $clog2(2 * WIDTH + 1);
    localparam logic [HCW-1:0] LAST_HALF   = HCW'(2 * WIDTH - 1);
    localparam logic [HCW-1:0] PENULT_HALF = HCW'(2 * WIDTH - 2);

    spi_state_e state, state_next;

    logic             phase_end;
    logic             div_clr;
    logic             accept;
    logic [HCW-1:0]   half_cnt;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;

    assign tx_ready_o = (state == IDLE) && !wb_rst_i;
    assign accept     = tx_valid_i && (state == IDLE);
    assign busy_o     = (state != IDLE);
    assign div_clr    = (state == IDLE) || (state_next != state);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .clr       (div_clr),
        .phase_end (phase_end)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   if (phase_end) state_next = SHIFT;
            SHIFT:   if (phase_end && (half_cnt == LAST_HALF)) state_next = HOLD;
            HOLD:    if (phase_end) state_next = GAP;
            GAP:     if (phase_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // half_cnt indexes the current SCK half-period inside SHIFT: even = high,
    // odd = low. The first rising edge is issued on leaving SETUP, so SHIFT
    // itself only produces W-1 further rises and W falls.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            spi_sck_o  <= SCK_IDLE;
            spi_csb_o  <= CSB_INACTIVE;
            spi_mosi_o <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            half_cnt   <= '0;
        end else begin
            rx_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_sr      <= tx_data_i;
                        spi_csb_o  <= CSB_ACTIVE;
                        spi_mosi_o <= tx_data_i[WIDTH-1];
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        spi_sck_o <= SCK_ACTIVE;
                        rx_sr     <= {rx_sr[WIDTH-2:0], spi_miso_i};
                        half_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (phase_end && (half_cnt != LAST_HALF)) begin
                        half_cnt <= half_cnt + HCW'(1);
                        if (spi_sck_o == SCK_ACTIVE) begin
                            spi_sck_o <= SCK_IDLE;
                            // The final falling edge leaves the LSB on MOSI.
                            if (half_cnt != PENULT_HALF) begin
                                tx_sr      <= {tx_sr[WIDTH-2:0], 1'b0};
                                spi_mosi_o <= tx_sr[WIDTH-2];
                            end
                        end else begin
                            spi_sck_o <= SCK_ACTIVE;
                            rx_sr     <= {rx_sr[WIDTH-2:0], spi_miso_i};
                        end
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        spi_csb_o  <= CSB_INACTIVE;
                        spi_mosi_o <= 1'b0;
                        rx_data_o  <= rx_sr;
                        rx_valid_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
